// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Moore-style: every control output decodes state_q; only illegalOp also looks at opcode.
module multicycle_control #(
   parameter bit ILLEGAL_HALT = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   output logic       pcWrite,
   output logic       pcWriteCond,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       irWrite,
   output logic       memToReg,
   output logic       regDst,
   output logic       regWrite,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] aluOp,
   output logic [1:0] pcSource,
   output logic [3:0] state,
   output logic       illegalOp
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_HALT   = 4'd14,
      S_IDLE   = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   assign state = state_q;

   always_comb begin
      state_d     = S_IDLE;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      memToReg    = 1'b0;
      regDst      = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      aluOp       = 2'b00;
      pcSource    = 2'b00;
      illegalOp   = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_HALT: state_d = S_HALT;
         S_FETCH: begin
            memRead = 1'b1;
            irWrite = 1'b1;
            aluSrcB = 2'b01;
            pcWrite = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            aluSrcB = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default: begin
                  illegalOp = 1'b1;
                  state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            memRead = 1'b1;
            iorD    = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            memToReg = 1'b1;
            regWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            memWrite = 1'b1;
            iorD     = 1'b1;
            state_d  = S_FETCH;
         end
         S_EXEC: begin
            aluSrcA = 1'b1;
            aluOp   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regDst   = 1'b1;
            regWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            aluSrcA     = 1'b1;
            aluOp       = 2'b01;
            pcWriteCond = 1'b1;
            pcSource    = 2'b01;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            pcWrite  = 1'b1;
            pcSource = 2'b10;
            state_d  = S_FETCH;
         end
         S_ADDIEX: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            regWrite = 1'b1;
            state_d  = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (ILLEGAL_HALT 0 and 1) walked through
// every instruction class; expected state/controls queued per cycle and compared at negedge.
module tb_multicycle_control;

   localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                          MEMWB = 4'd4, MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7,
                          BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11,
                          HALT = 4'd14, IDLE = 4'd15;

   typedef struct packed {
      logic [3:0] s0;
      logic [3:0] s1;
      logic       i0;
      logic       i1;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;

   logic       pcw0, pcwc0, iord0, mrd0, mwr0, irw0, m2r0, rdst0, rw0, asa0, ill0;
   logic [1:0] asb0, aop0, psrc0;
   logic [3:0] st0;
   logic       pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1, ill1;
   logic [1:0] asb1, aop1, psrc1;
   logic [3:0] st1;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   exp_t        sb[$];

   always #5 clk = ~clk;

   multicycle_control #(.ILLEGAL_HALT(1'b0)) dut0 (
      .clk(clk), .reset(reset), .opcode(opcode),
      .pcWrite(pcw0), .pcWriteCond(pcwc0), .iorD(iord0), .memRead(mrd0), .memWrite(mwr0),
      .irWrite(irw0), .memToReg(m2r0), .regDst(rdst0), .regWrite(rw0), .aluSrcA(asa0),
      .aluSrcB(asb0), .aluOp(aop0), .pcSource(psrc0), .state(st0), .illegalOp(ill0)
   );

   multicycle_control #(.ILLEGAL_HALT(1'b1)) dut1 (
      .clk(clk), .reset(reset), .opcode(opcode),
      .pcWrite(pcw1), .pcWriteCond(pcwc1), .iorD(iord1), .memRead(mrd1), .memWrite(mwr1),
      .irWrite(irw1), .memToReg(m2r1), .regDst(rdst1), .regWrite(rw1), .aluSrcA(asa1),
      .aluSrcB(asb1), .aluOp(aop1), .pcSource(psrc1), .state(st1), .illegalOp(ill1)
   );

   // Packing: {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,memToReg,regDst,regWrite,aluSrcA,aluSrcB,aluOp,pcSource}
   wire [15:0] ctl0 = {pcw0, pcwc0, iord0, mrd0, mwr0, irw0, m2r0, rdst0, rw0, asa0, asb0, aop0, psrc0};
   wire [15:0] ctl1 = {pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1, asb1, aop1, psrc1};

   function automatic logic [15:0] exp_ctl(input logic [3:0] s);
      logic pw, pwc, io, mr, mw, iw, m2r, rd, rw, sa;
      logic [1:0] sb_, op, ps;
      {pw, pwc, io, mr, mw, iw, m2r, rd, rw, sa} = '0;
      sb_ = 2'b00; op = 2'b00; ps = 2'b00;
      case (s)
         FETCH:  begin mr = 1; iw = 1; sb_ = 2'b01; pw = 1; end
         DECODE: sb_ = 2'b11;
         MEMADR: begin sa = 1; sb_ = 2'b10; end
         MEMRD:  begin mr = 1; io = 1; end
         MEMWB:  begin m2r = 1; rw = 1; end
         MEMWR:  begin mw = 1; io = 1; end
         EXEC:   begin sa = 1; op = 2'b10; end
         ALUWB:  begin rd = 1; rw = 1; end
         BRANCH: begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
         JUMP:   begin pw = 1; ps = 2'b10; end
         ADDIEX: begin sa = 1; sb_ = 2'b10; end
         ADDIWB: rw = 1;
         default: ;
      endcase
      return {pw, pwc, io, mr, mw, iw, m2r, rd, rw, sa, sb_, op, ps};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h, want %h", tag, $time, got, exp);
      end
   endtask

   // Push the expectation for the coming edge, clock it, then pop and compare.
   task automatic step(input logic [3:0] e0, input logic [3:0] e1, input logic i0, input logic i1);
      exp_t e;
      sb.push_back('{s0: e0, s1: e1, i0: i0, i1: i1});
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check_eq("state0", {28'd0, st0}, {28'd0, e.s0});
      check_eq("ctl0", {16'd0, ctl0}, {16'd0, exp_ctl(e.s0)});
      check_eq("ill0", {31'd0, ill0}, {31'd0, e.i0});
      check_eq("state1", {28'd0, st1}, {28'd0, e.s1});
      check_eq("ctl1", {16'd0, ctl1}, {16'd0, exp_ctl(e.s1)});
      check_eq("ill1", {31'd0, ill1}, {31'd0, e.i1});
      check_eq("rd_wr_excl0", {31'd0, mrd0 & mwr0}, 32'd0);
   endtask

   // Called while both DUTs sit in FETCH; seq lists the states after FETCH, ending in FETCH.
   task automatic run_op(input logic [5:0] op, input int unsigned n, input logic [19:0] seq);
      opcode = op;
      for (int unsigned i = 0; i < n; i++)
         step(seq[4*i +: 4], seq[4*i +: 4], 1'b0, 1'b0);
   endtask

   initial begin
      reset  = 1'b1;
      opcode = 6'b000000;
      step(IDLE, IDLE, 0, 0);
      step(IDLE, IDLE, 0, 0);
      reset = 1'b0;
      step(FETCH, FETCH, 0, 0);

      // lw; opcode scrambled once MEMRD is reached to show it is no longer sampled
      opcode = 6'b100011;
      step(DECODE, DECODE, 0, 0);
      step(MEMADR, MEMADR, 0, 0);
      step(MEMRD, MEMRD, 0, 0);
      opcode = 6'b101011;
      step(MEMWB, MEMWB, 0, 0);
      step(FETCH, FETCH, 0, 0);

      run_op(6'b101011, 4, {4'd0, FETCH, MEMWR, MEMADR, DECODE});
      run_op(6'b000000, 4, {4'd0, FETCH, ALUWB, EXEC, DECODE});
      run_op(6'b001000, 4, {4'd0, FETCH, ADDIWB, ADDIEX, DECODE});
      run_op(6'b000100, 3, {8'd0, FETCH, BRANCH, DECODE});
      run_op(6'b000010, 3, {8'd0, FETCH, JUMP, DECODE});

      // illegal opcode: dut0 loops FETCH/DECODE, dut1 parks in HALT
      opcode = 6'b111111;
      step(DECODE, DECODE, 1, 1);
      step(FETCH, HALT, 0, 0);
      for (int unsigned i = 0; i < 12; i++) begin
         if (i % 2 == 0) step(DECODE, HALT, 1, 0);
         else            step(FETCH, HALT, 0, 0);
      end
      reset = 1'b1;
      step(IDLE, IDLE, 0, 0);
      reset = 1'b0;
      step(FETCH, FETCH, 0, 0);

      // reset in MEMRD of a lw must suppress the MEMWB write-back
      opcode = 6'b100011;
      step(DECODE, DECODE, 0, 0);
      step(MEMADR, MEMADR, 0, 0);
      step(MEMRD, MEMRD, 0, 0);
      reset = 1'b1;
      step(IDLE, IDLE, 0, 0);
      reset = 1'b0;
      step(FETCH, FETCH, 0, 0);
      step(DECODE, DECODE, 0, 0);

      check_eq("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for the multi-cycle MIPS datapath.
- Sits directly upstream of the shared instruction/data Memory and drives its memRead/memWrite strobes.
- Also drives the IorD address mux, instruction-register load, register-file, ALU and PC controls.
- Sequences each instruction through FETCH, DECODE and its execution states, based on the opcode latched in the instruction register.

Parameters:
- ILLEGAL_HALT, 0: on an unsupported opcode, 0 returns to FETCH; 1 enters HALT and stays there until reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  instr[31:26] from the instruction register.
- pcWrite  output  1  unconditional PC load.
- pcWriteCond  output  1  PC load qualified by ALU zero (beq).
- iorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead  output  1  Memory read strobe.
- memWrite  output  1  Memory write strobe.
- irWrite  output  1  instruction register load.
- memToReg  output  1  write-back select: 1 = memory data register.
- regDst  output  1  destination register: 1 = rd, 0 = rt.
- regWrite  output  1  register file write enable.
- aluSrcA  output  1  ALU A operand: 0 = PC, 1 = register A.
- aluSrcB  output  2  ALU B operand: 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- aluOp  output  2  00 = add, 01 = sub, 10 = use funct.
- pcSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  output  4  current state encoding, for debug.
- illegalOp  output  1  high during DECODE when the opcode is unsupported.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. Reset while high (at any point, mid-instruction included) forces state to IDLE on the next rising edge.
- Output timing: all outputs are pure decodes of the state register; no combinational path from opcode except illegalOp.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=14, IDLE=15.
- Default: every output not listed for a state is 0.
- IDLE and HALT: all outputs 0; state output shows 15 or 14. This gives the reset value of every output = 0, state = 15.
- Per-state outputs:
  - IDLE: next state is always FETCH.
  - FETCH: memRead=1, iorD=0, irWrite=1, aluSrcA=0, aluSrcB=01, aluOp=00, pcWrite=1, pcSource=00. Next state DECODE.
  - DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) -> ADDIEX
    - anything else -> illegalOp=1 for this cycle, then FETCH (ILLEGAL_HALT=0) or HALT (ILLEGAL_HALT=1).
  - MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Next MEMRD if opcode=lw, otherwise MEMWR.
  - MEMRD: memRead=1, iorD=1. Next MEMWB.
  - MEMWB: regDst=0, memToReg=1, regWrite=1. Next FETCH.
  - MEMWR: memWrite=1, iorD=1. Next FETCH.
  - EXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Next ALUWB.
  - ALUWB: regDst=1, memToReg=0, regWrite=1. Next FETCH.
  - BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01. Next FETCH.
  - JUMP: pcWrite=1, pcSource=10. Next FETCH.
  - ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00. Next ADDIWB.
  - ADDIWB: regDst=0, memToReg=0, regWrite=1. Next FETCH.
- Cycles from FETCH back to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Opcode sampling: opcode is sampled only in DECODE and MEMADR. It is ignored in all other states, because the IR holds it stable after FETCH.
- Strobe exclusivity: memRead and memWrite are never both 1. memWrite is 1 only in MEMWR, exactly one cycle per sw. regWrite is 1 for exactly one cycle per lw, R-type or addi.
- Unused encodings (12, 13): next state is IDLE, all outputs 0.

Test Plan:
- Reset: hold reset=1 for 2 edges -> state=15, all control outputs 0. Release reset -> state=0 (FETCH) on the next edge, with memRead=1, irWrite=1, pcWrite=1, aluSrcB=01.
- lw sequence: opcode=6'b100011 -> states 0,1,2,3,4,0. memRead=1 with iorD=1 only in state 3; regWrite=1 with memToReg=1 only in state 4.
- sw sequence: opcode=6'b101011 -> states 0,1,2,5,0. memWrite=1 for exactly 1 cycle (state 5, iorD=1); memRead=0 in that cycle.
- R-type, addi and beq: opcode=0 -> 0,1,6,7,0 with aluOp=10 in state 6 and regDst=1 in state 7. opcode=6'b001000 -> 0,1,10,11,0 with regDst=0. opcode=6'b000100 -> 0,1,8,0 with pcWriteCond=1, pcSource=01.
- Illegal opcode: opcode=6'b111111 with ILLEGAL_HALT=0 -> illegalOp=1 in state 1, then FETCH. Repeat with ILLEGAL_HALT=1 -> state 14 held for 10+ cycles with all outputs 0 until reset=1.
- Reset mid-operation: assert reset during state 3 of a lw -> next edge state=15, no regWrite pulse ever issued for that lw.
